// File: rtl/params_mem_nbank.sv
// params_mem_nbank: NUM_BANKS single-port parameter banks behind one flat
// address space. One read port and one write port, each casting between the
// stored STO_W format and the COMP_W/COMP_Q compute format. Writes pass
// through a small FIFO that drains into the banks whenever the read port is
// not using the target bank. Reads of addresses still in the FIFO are served
// from it, youngest entry first.
module params_mem_nbank #(
    parameter int NUM_BANKS  = 2,
    parameter int BANK_DEPTH = 15872,
    parameter int STO_W      = 9,
    parameter int COMP_W     = 22,
    parameter int COMP_Q     = 10,
    parameter int WBUF_DEPTH = 4,
    parameter int ADDR_W     = $clog2(NUM_BANKS*BANK_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_fmt,
    output logic [COMP_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [COMP_W-1:0] wr_data,
    input  logic [1:0]        wr_fmt,
    output logic              wr_ready,
    output logic              busy,
    output logic              err_addr,
    input  logic              err_clr
);

    localparam int BK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int LOC_W = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
    localparam int SPAN  = NUM_BANKS * BANK_DEPTH;

    // Bank boundaries are compared rather than divided so NUM_BANKS need not
    // be a power of two.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(SPAN);
    endfunction

    function automatic logic [BK_W-1:0] addr_bank(input logic [ADDR_W-1:0] a);
        logic [BK_W-1:0] b;
        b = '0;
        for (int i = 1; i < NUM_BANKS; i++)
            if (32'(a) >= 32'(i * BANK_DEPTH)) b = BK_W'(i);
        return b;
    endfunction

    function automatic logic [LOC_W-1:0] addr_local(input logic [ADDR_W-1:0] a);
        logic [31:0] base;
        base = '0;
        for (int i = 1; i < NUM_BANKS; i++)
            if (32'(a) >= 32'(i * BANK_DEPTH)) base = 32'(i * BANK_DEPTH);
        return LOC_W'(32'(a) - base);
    endfunction

    // Position of the stored LSB inside the compute word; fmt encodes I-2.
    function automatic int fmt_shift(input logic [1:0] fmt);
        return COMP_Q - STO_W + 2 + int'(fmt);
    endfunction

    // Compute -> stored: keep the sign, truncate the rest (no saturation).
    function automatic logic [STO_W-1:0] to_sto(input logic [COMP_W-1:0] d,
                                                input logic [1:0] fmt);
        return {d[COMP_W-1], (STO_W-1)'(d >> fmt_shift(fmt))};
    endfunction

    // Stored -> compute: sign-extend above, zero-fill below.
    function automatic logic [COMP_W-1:0] to_comp(input logic [STO_W-1:0] s,
                                                  input logic [1:0] fmt);
        logic [COMP_W-1:0] e;
        e = {{(COMP_W-STO_W){s[STO_W-1]}}, s};
        return e << fmt_shift(fmt);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == 32'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
    logic [STO_W-1:0]  wb_data_q [WBUF_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    logic              rd_valid_q, rd_oor_q, rd_fwd_q;
    logic [BK_W-1:0]   rd_bank_q;
    logic [1:0]        rd_fmt_q;
    logic [STO_W-1:0]  rd_fwd_data_q;
    logic [COMP_W-1:0] rd_hold_q;

    logic              rd_ok, wr_ok, full, enq, drain, rd_mem, rd_err, wr_err;
    logic [BK_W-1:0]   rd_bank, head_bank;
    logic [LOC_W-1:0]  rd_local, head_local;
    logic              fwd_hit;
    logic [STO_W-1:0]  fwd_data;
    logic [NUM_BANKS-1:0] bank_we, bank_re;
    logic [NUM_BANKS-1:0][STO_W-1:0] bank_rdata;
    logic [STO_W-1:0]  rd_sto;
    logic [COMP_W-1:0] rd_cast;

    // Youngest buffered entry matching the read address (walk head -> tail).
    always_comb begin
        int j;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        j        = 0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            j = int'(head_q) + i;
            if (j >= WBUF_DEPTH) j = j - WBUF_DEPTH;
            if (i < int'(count_q) && wb_addr_q[PTR_W'(j)] == rd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data_q[PTR_W'(j)];
            end
        end
    end

    // Address decode, handshake, drain arbitration and next-state logic.
    always_comb begin
        rd_ok      = addr_ok(rd_addr);
        rd_bank    = addr_bank(rd_addr);
        rd_local   = addr_local(rd_addr);
        wr_ok      = addr_ok(wr_addr);
        head_bank  = addr_bank(wb_addr_q[head_q]);
        head_local = addr_local(wb_addr_q[head_q]);

        full   = (count_q == CNT_W'(WBUF_DEPTH));
        enq    = wr_en && !full && wr_ok;
        wr_err = wr_en && !full && !wr_ok;
        rd_err = rd_en && !rd_ok;
        // Any read aimed at the head's bank holds off the drain, forwarded or not.
        drain  = (count_q != '0) && !(rd_en && rd_ok && (rd_bank == head_bank));
        rd_mem = rd_en && rd_ok && !fwd_hit;

        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we[b] = drain && (head_bank == BK_W'(b));
            bank_re[b] = rd_mem && (rd_bank == BK_W'(b));
        end

        head_d  = drain ? ptr_inc(head_q) : head_q;
        tail_d  = enq ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        if (enq && !drain)      count_d = count_q + 1'b1;
        else if (!enq && drain) count_d = count_q - 1'b1;

        err_d = err_q;
        if (err_clr)          err_d = 1'b0;
        if (rd_err || wr_err) err_d = 1'b1;
    end

    // FIFO control and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // FIFO payload; the write cast happens here so entries hold stored format.
    always_ff @(posedge clk) begin
        if (enq) begin
            wb_addr_q[tail_q] <= wr_addr;
            wb_data_q[tail_q] <= to_sto(wr_data, wr_fmt);
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [STO_W-1:0] mem_q [BANK_DEPTH];
        logic [STO_W-1:0] rdata_q;

        // Single-port bank: either the drain write or the read, never both.
        always_ff @(posedge clk) begin
            if (bank_we[b])      mem_q[head_local] <= wb_data_q[head_q];
            else if (bank_re[b]) rdata_q <= mem_q[rd_local];
        end

        assign bank_rdata[b] = rdata_q;

        a_one_access: assert property (@(posedge clk) disable iff (!rst_n)
            !(bank_we[b] && bank_re[b]));
    end

    // Read pipeline: remember where this cycle's read is served from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q    <= 1'b0;
            rd_oor_q      <= 1'b0;
            rd_fwd_q      <= 1'b0;
            rd_bank_q     <= '0;
            rd_fmt_q      <= '0;
            rd_fwd_data_q <= '0;
            rd_hold_q     <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_oor_q      <= !rd_ok;
                rd_fwd_q      <= fwd_hit;
                rd_bank_q     <= rd_bank;
                rd_fmt_q      <= rd_fmt;
                rd_fwd_data_q <= fwd_data;
            end
            if (rd_valid_q) rd_hold_q <= rd_cast;
        end
    end

    // Output cast; rd_data holds the last delivered value between reads.
    always_comb begin
        rd_sto  = rd_fwd_q ? rd_fwd_data_q : bank_rdata[rd_bank_q];
        rd_cast = rd_oor_q ? '0 : to_comp(rd_sto, rd_fmt_q);
    end

    assign rd_data  = rd_valid_q ? rd_cast : rd_hold_q;
    assign rd_valid = rd_valid_q;
    assign wr_ready = !full;
    assign busy     = (count_q != '0);
    assign err_addr = err_q;

    a_no_enq_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(enq && full));
    a_rd_fmt_known: assert property (@(posedge clk) disable iff (!rst_n)
        rd_en |-> !$isunknown(rd_fmt));
    a_wr_fmt_known: assert property (@(posedge clk) disable iff (!rst_n)
        wr_en |-> !$isunknown(wr_fmt));

endmodule

// File: doc/params_mem_nbank.md
Name: params_mem_nbank

Overview:
Parametrised parameter store that replaces the fixed two-bank parameter memory. It provides NUM_BANKS single-port synchronous banks mapped as one contiguous address space. The block has one read port and one write port with per-access fixed-point format casting. A small write buffer absorbs bank conflicts, and reads of still-buffered addresses are forwarded from that buffer. It sits between the CiM datapath/loader and the parameter SRAM macros.

Parameters:
NUM_BANKS, 2, number of banks (>=1; need not be a power of two)
BANK_DEPTH, 15872, words per bank
STO_W, 9, stored parameter width in bits
COMP_W, 22, compute fixed-point width
COMP_Q, 10, compute fractional bits
WBUF_DEPTH, 4, write-buffer entries (>=1)
ADDR_W, $clog2(NUM_BANKS*BANK_DEPTH), derived global address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_en  in  1  read request
rd_addr  in  ADDR_W  global read address
rd_fmt  in  2  integer bits incl. sign: 0=2, 1=3, 2=4, 3=5
rd_data  out  COMP_W  cast read data
rd_valid  out  1  rd_data valid
wr_en  in  1  write request, accepted when wr_ready=1
wr_addr  in  ADDR_W  global write address
wr_data  in  COMP_W  write data in compute format
wr_fmt  in  2  storage format, same encoding as rd_fmt
wr_ready  out  1  write buffer not full
busy  out  1  write buffer non-empty
err_addr  out  1  sticky flag: out-of-range access attempted
err_clr  in  1  clears err_addr

Behaviour:
- Reset (async, rst_n=0): rd_valid=0, rd_data=0, wr_ready=1, busy=0, err_addr=0, buffer emptied. Bank contents are not reset. Pending buffered writes are discarded.
- Mapping: bank = addr / BANK_DEPTH, local = addr - bank*BANK_DEPTH. Addresses >= NUM_BANKS*BANK_DEPTH are out of range.
- Out-of-range read: no bank access; rd_valid=1 next cycle with rd_data=0; err_addr set.
- Out-of-range write: the handshake completes, the data is dropped, and err_addr is set.
- err_clr clears err_addr. A same-cycle new error wins, so the flag stays 1.
- Read latency is exactly 1 cycle: rd_en in cycle N gives rd_valid=1 in N+1 only. A new read is allowed every cycle. rd_data holds its last value when rd_valid=0.
- Read cast (Param to Comp), I = integer bits from rd_fmt:
  - upper COMP_W-COMP_Q-I bits = sign;
  - then the STO_W stored bits;
  - lower COMP_Q-(STO_W-I) bits = 0 (zero-fill, not sign-fill).
- Write cast (Comp to Param): {sign, wr_data[COMP_Q+I-2 : COMP_Q-(STO_W-I)]}. Truncation, no saturation. The cast is applied at enqueue, so the buffer stores STO_W bits plus the address.
- Write buffer is a FIFO. Entries enqueue when wr_en and wr_ready are both 1. wr_ready = !full (combinational on the current count). busy = count != 0.
- Drain: each cycle the head entry is written to its bank unless rd_en targets the same bank in that cycle. Reads always have priority.
  - At most one drain per cycle.
  - With an empty FIFO and no conflict, an incoming write still enqueues and drains the next cycle, giving a fixed 1-cycle minimum write latency.
- Simultaneous enqueue and drain while full: not allowed, because wr_ready is 0 when full. Enqueue and drain in the same cycle when not full leaves count unchanged.
- Forwarding: if rd_addr matches any buffered entry, including one draining this cycle, return the youngest match cast with rd_fmt. The bank is not read for that access.
  - A write enqueued in the same cycle as a read to the same address is not forwarded; the read returns the old value.
- Starvation: a bank read every cycle blocks the drain indefinitely. This is legal, and wr_ready backpressures the writer.
- Assertions: at most one access per bank per cycle; no enqueue when full; rd_fmt/wr_fmt are known (not X) when their enable is 1.

Test Plan:
- Reset, then wr addr 5, fmt 2, data 0x00600 (1.5); wait 2 cycles; rd addr 5, fmt 2 -> stored 0x030; rd_data=0x00600, rd_valid exactly 1 cycle later.
- Write -2.25 (0x3FF700) to addr BANK_DEPTH+3 with fmt 1 -> bank 1 local 3 stores 0x170; readback fmt 1 = 0x3FF700.
- Write addr 7 then rd addr 7 the cycle after enqueue, while the drain is blocked by reads to bank 0 -> forwarded data correct; busy=1 until the reads stop.
- Continuous bank-0 reads with 5 writes to bank 0 -> wr_ready=0 after 4 enqueues; drain and ready resume within 1 cycle after reads stop; all 5 writes land in order. Two writes to the same address: the later value wins.
- rd addr NUM_BANKS*BANK_DEPTH -> rd_data=0, rd_valid=1, err_addr=1. err_clr in the same cycle as a new error -> err_addr stays 1.
- Assert rst_n mid-stream with 3 buffered writes -> outputs reset immediately; the buffered writes are never committed (readback shows the old contents).
